ball_paddle_engine: RTL and testbench

Parametrised successor to the single-object game logic block. It owns ball and paddle state on a fixed tick and resolves wall, paddle and miss collisions. It also tracks lives. Each changed object is sent to the VGA plotter through a start/done handshake: one outstanding request at a time, ball first, then paddle.

---
 rtl/game_pkg.sv | 25 ++
 rtl/tick_divider.sv | 32 +++
 rtl/ball_paddle_engine.sv | 254 +++++++++++++++++++++++++
 tb/tb_ball_paddle_engine.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types for the ball/paddle game engine:
// plotter object codes, FSM states, direction bits.
package game_pkg;

  typedef enum logic [1:0] {
    OBJ_BALL   = 2'b00,
    OBJ_PADDLE = 2'b01,
    OBJ_NONE   = 2'b11
  } obj_e;

  typedef enum logic [2:0] {
    IDLE,
    BALL_UPD,
    BALL_PLOT,
    PAD_UPD,
    PAD_PLOT,
    OVER
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

endpackage

// File: rtl/tick_divider.sv
// Free-running game tick generator: one-cycle pulse
// on the last count of every TICK_CYCLES-cycle period.
module tick_divider #(
  parameter int unsigned TICK_CYCLES = 833333
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW =
    (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count wraps back to zero after the last value
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == LAST) cnt_d = '0;
  end

  // Period counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/ball_paddle_engine.sv
// Ball/paddle game state with wall, paddle and miss
// handling; changed objects are sent to the plotter.
module ball_paddle_engine
  import game_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 833333,
  parameter int unsigned X_W         = 8,
  parameter int unsigned Y_W         = 7,
  parameter int unsigned MAX_X       = 159,
  parameter int unsigned MAX_Y       = 119,
  parameter int unsigned BALL_SIZE   = 2,
  parameter int unsigned PADDLE_LEN  = 16,
  parameter int unsigned PADDLE_Y    = 115,
  parameter int unsigned PADDLE_STEP = 1,
  parameter int unsigned BALL_X0     = 51,
  parameter int unsigned BALL_Y0     = 25,
  parameter int unsigned PADDLE_X0   = 72,
  parameter int unsigned LIVES       = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           move_left,
  input  logic           move_right,
  input  logic           plot_done,
  output logic           start_plot,
  output logic [1:0]     object,
  output logic [X_W-1:0] new_x,
  output logic [Y_W-1:0] new_y,
  output logic [X_W-1:0] old_x,
  output logic [Y_W-1:0] old_y,
  output logic [X_W-1:0] size_x,
  output logic [Y_W-1:0] size_y,
  output logic [2:0]     lives,
  output logic           game_over
);

  localparam logic [X_W-1:0] BX_LIM =
    X_W'(MAX_X + 1 - BALL_SIZE);
  localparam logic [Y_W-1:0] BY_LIM =
    Y_W'(MAX_Y + 1 - BALL_SIZE);
  localparam logic [Y_W-1:0] BY_HIT =
    Y_W'(PADDLE_Y - BALL_SIZE);
  localparam logic [X_W-1:0] PX_LIM =
    X_W'(MAX_X + 1 - PADDLE_LEN);
  localparam logic [X_W:0]   PX_LIM_W =
    (X_W+1)'(MAX_X + 1 - PADDLE_LEN);
  localparam logic [X_W-1:0] BX0  = X_W'(BALL_X0);
  localparam logic [Y_W-1:0] BY0  = Y_W'(BALL_Y0);
  localparam logic [X_W-1:0] PX0  = X_W'(PADDLE_X0);
  localparam logic [Y_W-1:0] PY   = Y_W'(PADDLE_Y);
  localparam logic [X_W-1:0] BSX  = X_W'(BALL_SIZE);
  localparam logic [Y_W-1:0] BSY  = Y_W'(BALL_SIZE);
  localparam logic [X_W-1:0] PLEN = X_W'(PADDLE_LEN);
  localparam logic [X_W-1:0] STEP = X_W'(PADDLE_STEP);
  localparam logic [X_W:0]   BS_W = (X_W+1)'(BALL_SIZE);
  localparam logic [X_W:0]   PL_W = (X_W+1)'(PADDLE_LEN);
  localparam logic [X_W:0]   ST_W = (X_W+1)'(PADDLE_STEP);

  logic tick;

  state_e         state_q;
  logic           pending_q;
  logic           start_q;
  obj_e           obj_q;
  logic [X_W-1:0] new_x_q, old_x_q, size_x_q;
  logic [Y_W-1:0] new_y_q, old_y_q, size_y_q;
  logic [X_W-1:0] ball_x_q, ball_x_d;
  logic [Y_W-1:0] ball_y_q, ball_y_d;
  logic           dir_x_q, dir_x_d;
  logic           dir_y_q, dir_y_d;
  logic [X_W-1:0] pad_x_q, pad_x_d;
  logic [2:0]     lives_q;
  logic           over_q;
  logic           miss;
  logic           pad_hit;

  tick_divider #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign pad_hit = (dir_y_q == DIR_DOWN)
    && (ball_y_q == BY_HIT)
    && (({1'b0, ball_x_q} + BS_W) > {1'b0, pad_x_q})
    && ({1'b0, ball_x_q} < ({1'b0, pad_x_q} + PL_W));

  // Ball move for this tick, reflecting without a lag tick
  always_comb begin
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    miss     = 1'b0;
    if (dir_x_q == DIR_RIGHT) begin
      if (ball_x_q >= BX_LIM) begin
        dir_x_d  = DIR_LEFT;
        ball_x_d = ball_x_q - X_W'(1);
      end else begin
        ball_x_d = ball_x_q + X_W'(1);
      end
    end else begin
      if (ball_x_q == '0) begin
        dir_x_d  = DIR_RIGHT;
        ball_x_d = ball_x_q + X_W'(1);
      end else begin
        ball_x_d = ball_x_q - X_W'(1);
      end
    end
    if (dir_y_q == DIR_UP) begin
      if (ball_y_q == '0) begin
        dir_y_d  = DIR_DOWN;
        ball_y_d = ball_y_q + Y_W'(1);
      end else begin
        ball_y_d = ball_y_q - Y_W'(1);
      end
    end else if (pad_hit) begin
      dir_y_d  = DIR_UP;
      ball_y_d = ball_y_q - Y_W'(1);
    end else if (ball_y_q >= BY_LIM) begin
      miss = 1'b1;
    end else begin
      ball_y_d = ball_y_q + Y_W'(1);
    end
    if (miss) begin
      ball_x_d = BX0;
      ball_y_d = BY0;
      dir_x_d  = DIR_RIGHT;
      dir_y_d  = DIR_DOWN;
    end
  end

  // Clamped paddle position; conflicting requests cancel
  always_comb begin
    pad_x_d = pad_x_q;
    if (move_left && !move_right) begin
      if (pad_x_q < STEP) pad_x_d = '0;
      else                pad_x_d = pad_x_q - STEP;
    end else if (move_right && !move_left) begin
      if (({1'b0, pad_x_q} + ST_W) > PX_LIM_W)
        pad_x_d = PX_LIM;
      else
        pad_x_d = pad_x_q + STEP;
    end
  end

  // Game FSM with registered plot request outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      start_q   <= 1'b0;
      obj_q     <= OBJ_NONE;
      new_x_q   <= '0;
      new_y_q   <= '0;
      old_x_q   <= '0;
      old_y_q   <= '0;
      size_x_q  <= '0;
      size_y_q  <= '0;
      ball_x_q  <= BX0;
      ball_y_q  <= BY0;
      dir_x_q   <= DIR_RIGHT;
      dir_y_q   <= DIR_DOWN;
      pad_x_q   <= PX0;
      lives_q   <= 3'(LIVES);
      over_q    <= 1'b0;
    end else begin
      if (tick && state_q != IDLE && state_q != OVER)
        pending_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (tick || pending_q) begin
            pending_q <= 1'b0;
            state_q   <= BALL_UPD;
          end
        end
        BALL_UPD: begin
          old_x_q <= ball_x_q;
          old_y_q <= ball_y_q;
          if (miss) lives_q <= lives_q - 3'd1;
          if (miss && lives_q == 3'd1) begin
            over_q  <= 1'b1;
            obj_q   <= OBJ_NONE;
            state_q <= OVER;
          end else begin
            ball_x_q <= ball_x_d;
            ball_y_q <= ball_y_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
            new_x_q  <= ball_x_d;
            new_y_q  <= ball_y_d;
            size_x_q <= BSX;
            size_y_q <= BSY;
            obj_q    <= OBJ_BALL;
            start_q  <= 1'b1;
            state_q  <= BALL_PLOT;
          end
        end
        BALL_PLOT: begin
          if (start_q) begin
            start_q <= 1'b0;
          end else if (plot_done) begin
            obj_q   <= OBJ_NONE;
            state_q <= PAD_UPD;
          end
        end
        PAD_UPD: begin
          if (pad_x_d != pad_x_q) begin
            pad_x_q  <= pad_x_d;
            old_x_q  <= pad_x_q;
            new_x_q  <= pad_x_d;
            old_y_q  <= PY;
            new_y_q  <= PY;
            size_x_q <= PLEN;
            size_y_q <= Y_W'(1);
            obj_q    <= OBJ_PADDLE;
            start_q  <= 1'b1;
            state_q  <= PAD_PLOT;
          end else begin
            state_q <= IDLE;
          end
        end
        PAD_PLOT: begin
          if (start_q) begin
            start_q <= 1'b0;
          end else if (plot_done) begin
            obj_q   <= OBJ_NONE;
            state_q <= IDLE;
          end
        end
        OVER: begin
          state_q <= OVER;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign start_plot = start_q;
  assign object     = obj_q;
  assign new_x      = new_x_q;
  assign new_y      = new_y_q;
  assign old_x      = old_x_q;
  assign old_y      = old_y_q;
  assign size_x     = size_x_q;
  assign size_y     = size_y_q;
  assign lives      = lives_q;
  assign game_over  = over_q;

endmodule

// File: tb/tb_ball_paddle_engine.sv
// Bench for ball_paddle_engine: directed table, random
// paddle play against a reference model, reset cases.
module tb_ball_paddle_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       move_left = 1'b0;
  logic       move_right = 1'b0;
  logic       plot_done = 1'b0;
  logic       start_plot;
  logic [1:0] object;
  logic [7:0] new_x, old_x, size_x;
  logic [6:0] new_y, old_y, size_y;
  logic [2:0] lives;
  logic       game_over;

  int n_chk = 0;
  int n_fail = 0;
  bit tmo = 1'b0;

  always #5 clk = ~clk;

  ball_paddle_engine #(
    .TICK_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .move_left (move_left),
    .move_right(move_right),
    .plot_done (plot_done),
    .start_plot(start_plot),
    .object    (object),
    .new_x     (new_x),
    .new_y     (new_y),
    .old_x     (old_x),
    .old_y     (old_y),
    .size_x    (size_x),
    .size_y    (size_y),
    .lives     (lives),
    .game_over (game_over)
  );

  typedef struct {
    int ox; int oy; int nx; int ny;
    int sx; int sy; int obj;
  } req_t;

  typedef struct {
    bit ml; bit mr;
    int box; int boy; int bnx; int bny;
    bit pm; int pox; int pnx;
  } vec_t;

  // Reference game state: plain integers, +1/-1 directions
  int mbx, mby, mdx, mdy, mpad, mlives;

  task automatic check(input string nm,
                       input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mbx = 51; mby = 25; mdx = 1; mdy = 1;
    mpad = 72; mlives = 3;
  endtask

  task automatic model_ball(output bit over,
                            output req_t r);
    int nx, ny, ndx, ndy;
    bit miss;
    ndx = mdx; ndy = mdy; miss = 1'b0;
    nx = mbx; ny = mby;
    r.ox = mbx; r.oy = mby;
    if (mdx > 0 && mbx + 2 > 159) begin
      ndx = -1; nx = mbx - 1;
    end else if (mdx < 0 && mbx == 0) begin
      ndx = 1; nx = 1;
    end else nx = mbx + mdx;
    if (mdy < 0 && mby == 0) begin
      ndy = 1; ny = 1;
    end else if (mdy > 0 && mby + 2 == 115 &&
                 mbx + 2 > mpad && mbx < mpad + 16) begin
      ndy = -1; ny = mby - 1;
    end else if (mdy > 0 && mby + 2 > 119) begin
      miss = 1'b1;
    end else ny = mby + mdy;
    over = 1'b0;
    if (miss) begin
      mlives--;
      if (mlives == 0) over = 1'b1;
      nx = 51; ny = 25; ndx = 1; ndy = 1;
    end
    mbx = nx; mby = ny; mdx = ndx; mdy = ndy;
    r.nx = nx; r.ny = ny;
    r.sx = 2; r.sy = 2; r.obj = 0;
  endtask

  task automatic model_pad(input bit ml, input bit mr,
                           output bit moved,
                           output req_t r);
    int np;
    np = mpad;
    if (ml && !mr) np = (mpad - 1 < 0) ? 0 : mpad - 1;
    if (mr && !ml) np = (mpad + 1 > 144) ? 144 : mpad + 1;
    moved = (np != mpad);
    r.ox = mpad; r.nx = np; r.oy = 115; r.ny = 115;
    r.sx = 16; r.sy = 1; r.obj = 1;
    mpad = np;
  endtask

  function automatic int impact_x(input int x0, input int dx0,
                                  input int y0, input int dy0);
    int x, dx, y, dy;
    x = x0; dx = dx0; y = y0; dy = dy0;
    for (int k = 0; k < 600; k++) begin
      if (dy > 0 && y >= 113) return x;
      if (dx > 0 && x >= 158) begin dx = -1; x--; end
      else if (dx < 0 && x == 0) begin dx = 1; x++; end
      else x += dx;
      if (dy < 0 && y == 0) begin dy = 1; y++; end
      else y += dy;
    end
    return x;
  endfunction

  task automatic wait_req(input int lim);
    int w;
    w = 0;
    while (!start_plot && w < lim) begin
      plot_done = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      w++;
    end
    plot_done = 1'b0;
    if (!start_plot) begin
      n_chk++; n_fail++; tmo = 1'b1;
      $display("FAIL plot_wait: start_plot still %0d after %0d cycles, required 1",
               start_plot, w);
    end
  endtask

  task automatic serve(input req_t e, input bit is_ball);
    int d;
    wait_req(300);
    if (tmo) return;
    check("object", object, e.obj);
    check("old_x", old_x, e.ox);
    check("old_y", old_y, e.oy);
    check("new_x", new_x, e.nx);
    check("new_y", new_y, e.ny);
    check("size_x", size_x, e.sx);
    check("size_y", size_y, e.sy);
    if (is_ball) begin
      check("lives", lives, mlives);
      check("game_over", game_over, 0);
    end
    plot_done = 1'($urandom_range(0, 1));
    d = $urandom_range(0, 3);
    for (int i = 0; i <= d; i++) begin
      @(negedge clk);
      plot_done = 1'b0;
      check("pulse_once", start_plot, 0);
      check("hold_obj", object, e.obj);
      check("hold_new", {new_x, 1'b0, new_y},
            {e.nx[7:0], 1'b0, e.ny[6:0]});
      check("hold_old", {old_x, 1'b0, old_y},
            {e.ox[7:0], 1'b0, e.oy[6:0]});
    end
    plot_done = 1'b1;
    @(negedge clk);
    plot_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic latency_check();
    int c;
    c = 0;
    while (!start_plot && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("first_latency", c, 5);
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    req_t r, e;
    bit ov, moved, ml, mr, reached;
    int ix, tgt, seen;

    tbl[0] = '{0, 0, 51, 25, 52, 26, 0, 0, 0};
    tbl[1] = '{1, 0, 52, 26, 53, 27, 1, 72, 71};
    tbl[2] = '{1, 1, 53, 27, 54, 28, 0, 0, 0};
    tbl[3] = '{0, 1, 54, 28, 55, 29, 1, 71, 72};
    tbl[4] = '{0, 1, 55, 29, 56, 30, 1, 72, 73};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_start", start_plot, 0);
    check("rst_object", object, 3);
    check("rst_coords", {new_x, new_y, old_x, old_y}, 0);
    check("rst_sizes", {size_x, size_y}, 0);
    check("rst_lives", lives, 3);
    check("rst_over", game_over, 0);

    model_reset();
    reset = 1'b0;
    latency_check();

    foreach (tbl[i]) begin
      if (tmo) break;
      move_left = tbl[i].ml;
      move_right = tbl[i].mr;
      model_ball(ov, r);
      e = '{tbl[i].box, tbl[i].boy, tbl[i].bnx,
            tbl[i].bny, 2, 2, 0};
      serve(e, 1'b1);
      model_pad(tbl[i].ml, tbl[i].mr, moved, r);
      if (tbl[i].pm) begin
        e = '{tbl[i].pox, 115, tbl[i].pnx, 115, 16, 1, 1};
        serve(e, 1'b0);
      end
    end

    reached = 1'b0;
    for (int n = 0; n < 2500 && !tmo; n++) begin
      ix = impact_x(mbx, mdx, mby, mdy);
      if (n < 300) begin
        tgt = ix - 7;
        if (tgt < 0) tgt = 0;
        if (tgt > 144) tgt = 144;
        ml = (mpad > tgt);
        mr = (mpad < tgt);
        if ($urandom_range(0, 3) == 0)
          {ml, mr} = 2'($urandom_range(0, 3));
      end else begin
        ml = (ix >= 80);
        mr = (ix < 80);
      end
      move_left = ml;
      move_right = mr;
      model_ball(ov, r);
      if (ov) begin
        reached = 1'b1;
        break;
      end
      serve(r, 1'b1);
      model_pad(ml, mr, moved, r);
      if (moved) serve(r, 1'b0);
    end
    if (!reached && !tmo) begin
      n_chk++; n_fail++;
      $display("FAIL reach_over: lives %0d, required 0 within budget",
               lives);
    end

    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (start_plot) seen++;
    end
    check("over_no_plot", seen, 0);
    check("over_flag", game_over, 1);
    check("over_lives", lives, 0);
    check("over_object", object, 3);

    reset = 1'b1;
    move_left = 1'b0;
    move_right = 1'b0;
    @(negedge clk);
    check("rst2_over", game_over, 0);
    check("rst2_lives", lives, 3);
    model_reset();
    tmo = 1'b0;
    reset = 1'b0;
    wait_req(50);
    check("mid_object", object, 0);
    check("mid_new", {new_x, 1'b0, new_y},
          {8'd52, 1'b0, 7'd26});
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_start", start_plot, 0);
    check("mid_rst_object", object, 3);
    check("mid_rst_lives", lives, 3);
    @(negedge clk);
    reset = 1'b0;
    latency_check();
    model_ball(ov, r);
    serve(r, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
